// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_arb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int REQ_CPU   = 0;
  localparam int REQ_DEBUG = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage : uart_arb_pkg

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the two requesters, the arbiter and the UART transmitter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_valid;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_ready;
  logic [NUM_REQ-1:0]            grant;

  // Arbiter side: consumes requests and the transmitter's ready.
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant
  );

  // Environment side: requesters plus the UART transmitter.
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant
  );

endinterface : uart_tx_arbiter_if

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; rr_ptr names the preferred requester when both ask.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  // Lone requester always wins; a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule : rr_arbiter2

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmit byte port between the CPU path and the debug streamer.
// Grant is held for a whole packet, limited by a burst count and an idle timeout.
//
// state | meaning
// IDLE  | no owner, outputs low; arbitrate any valid request
// BUSY  | grant_q owns the port; bytes pass straight through
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_TC = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_TC  = IW'(HOLD_TIMEOUT - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [IW-1:0]      idle_cnt_q, idle_cnt_d;

  logic               owner;
  logic               own_valid;
  logic               own_last;
  logic               xfer;
  logic               release_now;
  logic [NUM_REQ-1:0] arb_gnt;

  rr_arbiter2 u_rr (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt)
  );

  // Pass-through datapath steered by the registered grant.
  always_comb begin
    owner         = grant_q[REQ_DEBUG];
    own_valid     = bus.req_valid[owner];
    own_last      = bus.req_last[owner];
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;
    if (state_q == BUSY) begin
      bus.tx_valid = own_valid;
      if (own_valid) begin
        bus.tx_data = owner ? bus.req_data[REQ_DEBUG*DATA_WIDTH +: DATA_WIDTH]
                            : bus.req_data[REQ_CPU*DATA_WIDTH +: DATA_WIDTH];
      end
      bus.req_ready[owner] = bus.tx_ready;
    end
  end

  assign bus.grant = grant_q;

  // Release on end of packet, burst exhaustion, or the owner going quiet too long.
  always_comb begin
    xfer        = (state_q == BUSY) && own_valid && bus.tx_ready;
    release_now = (state_q == BUSY) &&
                  ((xfer && (own_last || (burst_cnt_q == BURST_TC))) ||
                   (!own_valid && (idle_cnt_q == IDLE_TC)));
  end

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          state_d     = BUSY;
          grant_d     = arb_gnt;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d     = IDLE;
          grant_d     = '0;
          rr_ptr_d    = ~owner;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          idle_cnt_d  = '0;
        end else if (!own_valid) begin
          idle_cnt_d  = idle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Control registers; reset wins over any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (MAX_BURST=16, HOLD_TIMEOUT=4).
module tb_uart_tx_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_tx_arbiter_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_arbiter #(
    .DATA_WIDTH   (8),
    .MAX_BURST    (16),
    .HOLD_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_last  = 2'b00;
    bus.req_data  = 16'h0000;
    bus.tx_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state
    do_reset();
    #1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);

    // Lone requester 0, 3-byte packet
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h0041;
    #1;
    chk("p3_pre_grant", 32'(bus.grant), 32'h0);
    tick();
    chk("p3_grant", 32'(bus.grant), 32'h1);
    chk("p3_b0", 32'(bus.tx_data), 32'h41);
    chk("p3_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_data = 16'h0042;
    #1;
    chk("p3_b1", 32'(bus.tx_data), 32'h42);
    tick();
    bus.req_data = 16'h0043;
    bus.req_last = 2'b01;
    #1;
    chk("p3_b2", 32'(bus.tx_data), 32'h43);
    chk("p3_b2_grant", 32'(bus.grant), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    bus.req_last  = 2'b00;
    #1;
    chk("p3_release", 32'(bus.grant), 32'h0);
    chk("p3_idle_valid", 32'(bus.tx_valid), 32'h0);

    // Both requesters, continuous single-byte packets from reset
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_last  = 2'b11;
    bus.req_data  = 16'hB0A0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant", 32'(bus.grant), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_data", 32'(bus.tx_data), (i % 2 == 0) ? 32'hA0 : 32'hB0);
      tick();
      chk("rr_gap", 32'(bus.grant), 32'h0);
      chk("rr_gap_valid", 32'(bus.tx_valid), 32'h0);
    end

    // Burst limit: requester 1 streams 20 bytes, requester 0 waiting
    do_reset();
    bus.req_valid = 2'b10;
    bus.req_data  = 16'h1000;
    tick();
    chk("bl_grant1", 32'(bus.grant), 32'h2);
    bus.req_valid = 2'b11;
    bus.req_last  = 2'b01;
    bus.req_data  = 16'h1055;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("bl_byte", 32'(bus.tx_data), 32'h10 + 32'(k));
      chk("bl_hold", 32'(bus.grant), 32'h2);
      tick();
      bus.req_data[15:8] = 8'(8'h11 + k);
    end
    #1;
    chk("bl_release", 32'(bus.grant), 32'h0);
    tick();
    chk("bl_grant0", 32'(bus.grant), 32'h1);
    chk("bl_data0", 32'(bus.tx_data), 32'h55);
    tick();
    bus.req_valid = 2'b10;
    bus.req_last  = 2'b00;
    #1;
    chk("bl_rel0", 32'(bus.grant), 32'h0);
    tick();
    chk("bl_regrant1", 32'(bus.grant), 32'h2);
    for (int k = 16; k < 20; k++) begin
      bus.req_data[15:8] = 8'(8'h10 + k);
      bus.req_last       = (k == 19) ? 2'b10 : 2'b00;
      #1;
      chk("bl_tail", 32'(bus.tx_data), 32'h10 + 32'(k));
      tick();
    end
    bus.req_valid = 2'b00;
    bus.req_last  = 2'b00;
    #1;
    chk("bl_tail_rel", 32'(bus.grant), 32'h0);

    // Idle timeout: owner drops valid mid-packet
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h7161;
    tick();
    chk("to_grant", 32'(bus.grant), 32'h1);
    bus.req_valid = 2'b11;
    bus.req_last  = 2'b10;
    tick();
    bus.req_valid = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("to_hold", 32'(bus.grant), 32'h1);
    end
    tick();
    chk("to_release", 32'(bus.grant), 32'h0);
    tick();
    chk("to_grant1", 32'(bus.grant), 32'h2);
    chk("to_data1", 32'(bus.tx_data), 32'h71);
    tick();
    bus.req_valid = 2'b00;
    bus.req_last  = 2'b00;

    // Backpressure: tx_ready low for 10 cycles
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h0081;
    tick();
    chk("bp_grant", 32'(bus.grant), 32'h1);
    tick();
    bus.req_data = 16'h0082;
    bus.tx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_grant_hold", 32'(bus.grant), 32'h1);
      chk("bp_data_hold", 32'(bus.tx_data), 32'h82);
      chk("bp_ready_low", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.tx_ready = 1'b1;
    bus.req_last = 2'b01;
    #1;
    chk("bp_ready_up", 32'(bus.req_ready), 32'h1);
    chk("bp_data_go", 32'(bus.tx_data), 32'h82);
    tick();
    bus.req_valid = 2'b00;
    bus.req_last  = 2'b00;
    #1;
    chk("bp_release", 32'(bus.grant), 32'h0);

    // Reset during a BUSY handshake (owner 1, pointer left at 1)
    bus.req_valid = 2'b10;
    bus.req_data  = 16'h9100;
    tick();
    chk("rb_grant1", 32'(bus.grant), 32'h2);
    chk("rb_hs", 32'(bus.tx_valid & bus.tx_ready), 32'h1);
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data  = 16'h9190;
    #1;
    chk("rb_grant", 32'(bus.grant), 32'h0);
    chk("rb_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rb_tx_data", 32'(bus.tx_data), 32'h0);
    tick();
    chk("rb_rearb", 32'(bus.grant), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
